oled_spi_streamer: RTL and testbench
====================================

# oled_spi_streamer

Drives a 128x64 SSD1306 OLED over write-only 4-wire SPI. It is the consumer of the text engine's `pixelData`. After reset it pulses the panel reset, waits for power-up, and sends a fixed init command list. It then refreshes the screen continuously: it sets the address window, streams 1024 display bytes fetched through `pixelAddress`, pauses for a gap, and repeats.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles, minimum 1.
- `RST_CYCLES`, default 1000: cycles `oled_rst_n` is held low.
- `POWER_WAIT`, default 100000: cycles from panel-reset release to the first command.
- `FRAME_GAP`, default 256: idle cycles with `oled_cs_n` high between frames.
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `pixelAddress`, output, 10: display byte index. `[9:7]` = page, `[6:0]` = column.
- `pixelData`, input, 8: display byte for `pixelAddress`. The source registers it, so it is valid 1 cycle after the address.
- `oled_sclk`, output, 1: SPI clock, idle low.
- `oled_mosi`, output, 1: SPI data, MSB first.
- `oled_dc`, output, 1: 0 = command byte, 1 = data byte.
- `oled_cs_n`, output, 1: chip select, active low.
- `oled_rst_n`, output, 1: panel reset, active low.
- `initDone`, output, 1: set after the last init byte completes; cleared only by `reset`.
- `frame_done`, output, 1: one-cycle pulse at the end of each frame.

## Operation
- Reset values:
  - `oled_rst_n`=0, `oled_cs_n`=1, `oled_sclk`=0, `oled_mosi`=0, `oled_dc`=0.
  - `pixelAddress`=0, `initDone`=0, `frame_done`=0.
  - FSM in `RST_HOLD`.
- FSM states and transitions:
  - `RST_HOLD`: lasts `RST_CYCLES`, then `oled_rst_n`→1 and go to `PWR_WAIT`.
  - `PWR_WAIT`: lasts `POWER_WAIT`, then `INIT`.
  - `INIT`: sends 25 command bytes, then sets `initDone` and goes to `WINDOW`.
  - `WINDOW`: sends 6 command bytes, then `STREAM`.
  - `STREAM`: sends 1024 data bytes, then `GAP`.
  - `GAP`: lasts `FRAME_GAP`, then `WINDOW`.
- Init list, in order: AE, D5 80, A8 3F, D3 00, 40, 8D 14, 20 00, SEG, COM, DA 12, 81 CF, D9 F1, DB 40, A4, A6, AF.
  - SEG/COM are A0/C0 by default; see Configuration.
- Window list: 21 00 7F 22 00 07. This selects horizontal addressing over the full screen.
- `oled_cs_n` is low throughout `INIT`, `WINDOW` and `STREAM`, and high in all other states.
- `oled_dc` is 0 in `INIT`/`WINDOW` and 1 in `STREAM`. It changes only at byte loads.
- Byte shifter, SPI mode 0:
  - At byte load, bit7 drives `oled_mosi` with `oled_sclk` low.
  - `oled_sclk` toggles every `CLK_DIV` cycles.
  - `oled_mosi` advances on each falling edge.
  - The slave samples on rising edges.
  - After bit0's falling edge, the next byte loads in the same cycle, with no gap inside a state.
- Pixel fetch:
  - `pixelAddress` is 0 outside `STREAM`.
  - At the load of byte n in `STREAM`, `pixelData` is captured into the shifter and `pixelAddress`←n+1 (10-bit, wraps to 0 after 1023).
  - The address is therefore stable for ≥`16*CLK_DIV` cycles before the next capture.
- `frame_done` pulses in the cycle byte 1023's final falling edge occurs.
- `reset` asserted at any time returns every output to its reset value immediately and restarts the full sequence, including `RST_HOLD`. A partial byte is abandoned.

## Timing
- One byte takes exactly `16*CLK_DIV` cycles. SCLK period is `2*CLK_DIV`.
- Cycle counts with `CLK_DIV`=4:
  - `INIT` = 25×64 = 1600 cycles.
  - `WINDOW` = 384 cycles.
  - `STREAM` = 65536 cycles.
- Frame period = (6+1024)·16·`CLK_DIV` + `FRAME_GAP`.
- `oled_cs_n` falls in the same cycle as the first byte load of `INIT`/`WINDOW`.
- `oled_cs_n` rises in the cycle after the last bit's falling edge.
- `pixelData` must be valid ≥1 cycle after `pixelAddress` changes. The block requires no more than that.

## Configuration
- `OLED_ROTATE180_EN`:
  - Defined: SEG/COM init bytes are A1/C8, giving a 180° rotated image.
  - Undefined: A0/C0.
- No other behaviour or timing changes.

## Test plan
- Run with `CLK_DIV`=2, `RST_CYCLES`=10, `POWER_WAIT`=20. `oled_rst_n` rises at cycle 10. The first SCLK rise samples AE MSB=1. Decoded `dc`=0 bytes equal the 25-byte init list, then 21 00 7F 22 00 07.
- Drive `pixelData` = low byte of (registered address ^ {6'b0, addr[9:8]}). The 1024 decoded `dc`=1 bytes match, byte 0 uses address 0, and `frame_done` pulses exactly once.
- Check SCLK timing: period is 4 cycles, the high phase is 2 cycles, and MOSI changes only while SCLK is low.
- After the frame, `oled_cs_n` stays high for `FRAME_GAP` cycles, then the window bytes repeat and `initDone` stays 1.
- Assert `reset` mid-`STREAM` (byte 500): in the same cycle `oled_cs_n`=1, `oled_rst_n`=0, `pixelAddress`=0, `initDone`=0. The full init replays.
- Build with `OLED_ROTATE180_EN` defined: init bytes 13–14 are A1 C8. All other bytes are unchanged.

Source files
------------

// File: rtl/oled_spi_streamer.sv
// SSD1306 128x64 write-only 4-wire SPI streamer: panel reset, init list, then continuous frame refresh.
// Optional build macro OLED_ROTATE180_EN selects the 180-degree SEG/COM remap in the init list.
module oled_spi_streamer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RST_CYCLES = 1000,
  parameter int unsigned POWER_WAIT = 100000,
  parameter int unsigned FRAME_GAP  = 256
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pixelAddress,
  input  logic [7:0] pixelData,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_dc,
  output logic       oled_cs_n,
  output logic       oled_rst_n,
  output logic       initDone,
  output logic       frame_done
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWER_WAIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(FRAME_GAP - 1);

  localparam logic [2:0] S_RST_HOLD = 3'd0;
  localparam logic [2:0] S_PWR_WAIT = 3'd1;
  localparam logic [2:0] S_INIT     = 3'd2;
  localparam logic [2:0] S_WINDOW   = 3'd3;
  localparam logic [2:0] S_STREAM   = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

`ifdef OLED_ROTATE180_EN
  localparam logic [7:0] SEG_BYTE = 8'hA1;
  localparam logic [7:0] COM_BYTE = 8'hC8;
`else
  localparam logic [7:0] SEG_BYTE = 8'hA0;
  localparam logic [7:0] COM_BYTE = 8'hC0;
`endif

  function automatic logic [7:0] init_byte(input logic [4:0] idx);
    case (idx)
      5'd0:  init_byte = 8'hAE;
      5'd1:  init_byte = 8'hD5;
      5'd2:  init_byte = 8'h80;
      5'd3:  init_byte = 8'hA8;
      5'd4:  init_byte = 8'h3F;
      5'd5:  init_byte = 8'hD3;
      5'd6:  init_byte = 8'h00;
      5'd7:  init_byte = 8'h40;
      5'd8:  init_byte = 8'h8D;
      5'd9:  init_byte = 8'h14;
      5'd10: init_byte = 8'h20;
      5'd11: init_byte = 8'h00;
      5'd12: init_byte = SEG_BYTE;
      5'd13: init_byte = COM_BYTE;
      5'd14: init_byte = 8'hDA;
      5'd15: init_byte = 8'h12;
      5'd16: init_byte = 8'h81;
      5'd17: init_byte = 8'hCF;
      5'd18: init_byte = 8'hD9;
      5'd19: init_byte = 8'hF1;
      5'd20: init_byte = 8'hDB;
      5'd21: init_byte = 8'h40;
      5'd22: init_byte = 8'hA4;
      5'd23: init_byte = 8'hA6;
      5'd24: init_byte = 8'hAF;
      default: init_byte = 8'hE3;
    endcase
  endfunction

  // Column 0..127, page 0..7 window for horizontal addressing
  function automatic logic [7:0] window_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    window_byte = 8'h21;
      3'd1:    window_byte = 8'h00;
      3'd2:    window_byte = 8'h7F;
      3'd3:    window_byte = 8'h22;
      3'd4:    window_byte = 8'h00;
      3'd5:    window_byte = 8'h07;
      default: window_byte = 8'hE3;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [9:0]       byte_q, byte_d;
  logic [7:0]       sh_q, sh_d;
  logic             sclk_q, sclk_d;
  logic [9:0]       addr_q, addr_d;
  logic             dc_q, dc_d;
  logic             cs_n_q, cs_n_d;
  logic             rst_n_q, rst_n_d;
  logic             done_q, done_d;
  logic             fdone_q, fdone_d;

  logic             load;
  logic [7:0]       load_val;
  logic             byte_end;
  logic [9:0]       next_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST_HOLD;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      addr_q  <= '0;
      dc_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      rst_n_q <= 1'b0;
      done_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      addr_q  <= addr_d;
      dc_q    <= dc_d;
      cs_n_q  <= cs_n_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      fdone_q <= fdone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    sh_d     = sh_q;
    sclk_d   = sclk_q;
    addr_d   = addr_q;
    dc_d     = dc_q;
    cs_n_d   = cs_n_q;
    rst_n_d  = rst_n_q;
    done_d   = done_q;
    fdone_d  = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    byte_end = 1'b0;
    next_idx = byte_q + 10'd1;

    case (state_q)
      S_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          rst_n_d = 1'b1;
          cnt_d   = '0;
          state_d = S_PWR_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d  = S_INIT;
          byte_d   = '0;
          load     = 1'b1;
          load_val = init_byte(5'd0);
          cs_n_d   = 1'b0;
          dc_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INIT, S_WINDOW, S_STREAM: begin
        // Mode 0: MOSI shifts on the falling edge, the 8th fall ends the byte
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (bit_q == 3'd7) begin
              byte_end = 1'b1;
            end else begin
              sh_d  = {sh_q[6:0], 1'b0};
              bit_d = bit_q + 3'd1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end

        if (byte_end) begin
          if (state_q == S_INIT) begin
            load = 1'b1;
            if (byte_q == 10'd24) begin
              state_d  = S_WINDOW;
              done_d   = 1'b1;
              byte_d   = '0;
              load_val = window_byte(3'd0);
            end else begin
              byte_d   = next_idx;
              load_val = init_byte(next_idx[4:0]);
            end
          end else if (state_q == S_WINDOW) begin
            load = 1'b1;
            if (byte_q == 10'd5) begin
              state_d  = S_STREAM;
              byte_d   = '0;
              load_val = pixelData;
              addr_d   = 10'd1;
              dc_d     = 1'b1;
            end else begin
              byte_d   = next_idx;
              load_val = window_byte(next_idx[2:0]);
            end
          end else begin
            if (byte_q == 10'd1023) begin
              state_d = S_GAP;
              cnt_d   = '0;
              cs_n_d  = 1'b1;
              addr_d  = '0;
              fdone_d = 1'b1;
            end else begin
              load     = 1'b1;
              byte_d   = next_idx;
              load_val = pixelData;
              addr_d   = addr_q + 10'd1;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d  = S_WINDOW;
          byte_d   = '0;
          load     = 1'b1;
          load_val = window_byte(3'd0);
          cs_n_d   = 1'b0;
          dc_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_RST_HOLD;
    endcase

    if (load) begin
      sh_d   = load_val;
      bit_d  = '0;
      div_d  = '0;
      sclk_d = 1'b0;
    end
  end

  assign pixelAddress = addr_q;
  assign oled_sclk    = sclk_q;
  assign oled_mosi    = sh_q[7];
  assign oled_dc      = dc_q;
  assign oled_cs_n    = cs_n_q;
  assign oled_rst_n   = rst_n_q;
  assign initDone     = done_q;
  assign frame_done   = fdone_q;

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Scoreboard bench for oled_spi_streamer: decodes the SPI stream and compares against a queue of expected bytes.
module tb_oled_spi_streamer;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned RST_CYCLES = 10;
  localparam int unsigned POWER_WAIT = 20;
  localparam int unsigned FRAME_GAP  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData = 8'h00;
  logic       oled_sclk, oled_mosi, oled_dc, oled_cs_n, oled_rst_n;
  logic       initDone, frame_done;

  int checks = 0;
  int errors = 0;
  int data_seen = 0;
  int frame_cnt = 0;
  logic [7:0] key = 8'h00;
  logic [8:0] exp_q[$];
  logic [7:0] init_list [25];

  oled_spi_streamer #(
    .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .POWER_WAIT(POWER_WAIT), .FRAME_GAP(FRAME_GAP)
  ) dut (
    .clk(clk), .reset(reset), .pixelAddress(pixelAddress), .pixelData(pixelData),
    .oled_sclk(oled_sclk), .oled_mosi(oled_mosi), .oled_dc(oled_dc), .oled_cs_n(oled_cs_n),
    .oled_rst_n(oled_rst_n), .initDone(initDone), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Registered pixel source: one cycle of latency from address to data
  always @(posedge clk) pixelData <= src_byte(int'(pixelAddress));

  function automatic logic [7:0] src_byte(input int n);
    src_byte = 8'((n % 256) ^ (n / 256)) ^ key;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, init_list[i]});
  endtask

  task automatic push_window();
    logic [7:0] w [6];
    w = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, w[i]});
  endtask

  task automatic push_data(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, src_byte(i)});
  endtask

  // Monitor: SPI decode on SCLK rise, timing and idle checks, scoreboard pop
  initial begin
    logic prev_sclk, prev_cs, prev_mosi;
    logic [7:0] rx;
    logic [8:0] exp;
    int bitcnt, low_run, high_run, cs_run, nbytes;
    prev_sclk = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
    rx = '0; bitcnt = 0; low_run = 0; high_run = 0; cs_run = 0; nbytes = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        bitcnt = 0; low_run = 0; high_run = 0;
        if (oled_cs_n) cs_run++;
      end else begin
        if (oled_cs_n) begin
          cs_run++;
          check("addr_idle", pixelAddress, 0);
        end else begin
          if (prev_cs && initDone) check("cs_gap_len", cs_run, FRAME_GAP);
          cs_run = 0;
        end
        if (oled_sclk) high_run++;
        if (!oled_sclk && !oled_cs_n) low_run++;
        if (oled_cs_n) low_run = 0;
        if (oled_mosi != prev_mosi) check("mosi_chg_sclk", oled_sclk, 0);
        if (oled_sclk && !prev_sclk) begin
          check("sclk_low_len", low_run, CLK_DIV);
          low_run = 0;
          rx = {rx[6:0], oled_mosi};
          bitcnt++;
          if (bitcnt == 8) begin
            bitcnt = 0;
            nbytes++;
            if (oled_dc) data_seen++;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL spi_byte%0d: got %0h expected none", nbytes, {oled_dc, rx});
            end else begin
              exp = exp_q.pop_front();
              check($sformatf("spi_byte%0d", nbytes), {oled_dc, rx}, exp);
            end
          end
        end
        if (!oled_sclk && prev_sclk) begin
          check("sclk_high_len", high_run, CLK_DIV);
          high_run = 0;
        end
        if (frame_done) begin
          frame_cnt++;
          check("frame_done_pos", data_seen % 1024, 0);
          check("frame_done_init", initDone, 1);
        end
      end
      prev_sclk = oled_sclk; prev_cs = oled_cs_n; prev_mosi = oled_mosi;
    end
  end

  initial begin
    bit ok;
    init_list = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                  8'h20, 8'h00, 8'hA0, 8'hC0, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                  8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
`ifdef OLED_ROTATE180_EN
    init_list[12] = 8'hA1;
    init_list[13] = 8'hC8;
`endif
    reset = 1'b1;
    key = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_oled_rst_n", oled_rst_n, 0);
    check("rst_cs_n", oled_cs_n, 1);
    check("rst_sclk", oled_sclk, 0);
    check("rst_mosi", oled_mosi, 0);
    check("rst_dc", oled_dc, 0);
    check("rst_addr", pixelAddress, 0);
    check("rst_initdone", initDone, 0);
    check("rst_frame_done", frame_done, 0);

    push_init(); push_window(); push_data(1024); push_window(); push_data(1024);

    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 9)  check("rst_n_before", oled_rst_n, 0);
      if (cyc == 10) check("rst_n_rise", oled_rst_n, 1);
      if (cyc == 29) check("cs_before_init", oled_cs_n, 1);
      if (cyc == 30) check("cs_fall_init", oled_cs_n, 0);
    end

    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (oled_sclk) begin
        ok = 1'b1;
        check("first_rise_mosi", oled_mosi, 1);
      end
    end
    if (!ok) begin checks++; errors++; $display("FAIL first_sclk: got none expected rise"); end

    // Run through frame 1 and into byte 500 of frame 2
    ok = 1'b0;
    for (int i = 0; i < 60000 && !ok; i++) begin
      @(negedge clk);
      if (data_seen >= 1024 + 500) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL reach_byte500: got %0d expected %0d", data_seen, 1524);
    end else begin
      check("frames_before_rst", frame_cnt, 1);
      check("initdone_frame2", initDone, 1);
      repeat ($urandom_range(1, 25)) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_cs_n", oled_cs_n, 1);
      check("midrst_rst_n", oled_rst_n, 0);
      check("midrst_addr", pixelAddress, 0);
      check("midrst_initdone", initDone, 0);
      check("midrst_sclk", oled_sclk, 0);
      exp_q.delete();
      key = 8'($urandom);
      repeat (3) @(negedge clk);
      push_init(); push_window(); push_data(20);
      reset = 1'b0;

      ok = 1'b0;
      for (int i = 0; i < 5000 && !ok; i++) begin
        @(negedge clk);
        if (exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL replay_drain: got %0d expected 0", exp_q.size());
      end
      check("initdone_replay", initDone, 1);
      check("frames_after_rst", frame_cnt, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
